// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage: read-side drain of a registered-read FIFO.
// Pops into fifo_ctrl and streams words out through a 2-entry skid buffer.
module fifo_rd_stage #(
    parameter int DATA_BW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [DATA_BW-1:0] fifo_dout,
    output logic               rd_dout,
    input  logic               flush,
    output logic               out_valid,
    output logic [DATA_BW-1:0] out_data,
    input  logic               out_ready
);

    logic [DATA_BW-1:0] buf_mem [2];
    logic               head;
    logic               tail;
    logic [1:0]         buf_cnt;
    logic               inflight;
    logic               deq;
    logic               capture;
    logic [2:0]         occ;

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_mem[head];
    assign deq       = out_valid & out_ready;
    assign capture   = inflight & ~flush;

    // Occupancy after this cycle's dequeue, counting the word in flight.
    assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, deq};

    assign rd_dout = rst_n & ~fifo_empty & ~flush & (occ <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_cnt    <= 2'd0;
            inflight   <= 1'b0;
        end else if (flush) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_cnt    <= 2'd0;
            inflight   <= 1'b0;
        end else begin
            inflight <= rd_dout;
            if (capture) begin
                buf_mem[tail] <= fifo_dout;
                tail          <= ~tail;
            end
            if (deq) begin
                head <= ~head;
            end
            unique case ({capture, deq})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(capture && buf_cnt == 2'd2)
    );

endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb_fifo_rd_stage: directed checks of the FIFO read drain stage.
// A small registered-read FIFO model feeds the DUT.
module tb_fifo_rd_stage;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       rd_dout;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    logic [7:0] fmem [64];
    logic [5:0] frp;
    logic [5:0] fwp;
    logic [5:0] start;
    int         total;
    int         bad;
    int         exp_w;

    fifo_rd_stage #(.DATA_BW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .rd_dout    (rd_dout),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (frp >= fwp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frp <= 6'd0;
        end else if (rd_dout) begin
            fifo_dout <= fmem[frp];
            frp       <= frp + 6'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[fwp] = 8'(base + 8'(i));
            fwp = fwp + 6'd1;
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        fwp       = 6'd0;
        fifo_dout = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        load(8'h5A, 1);
        tick();
        tick();
        check("rst_rd", 32'(rd_dout), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(dut.buf_cnt), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_rd", 32'(rd_dout), 32'd1);
        tick();
        check("rel_infl", 32'(dut.inflight), 32'd1);
        check("rel_rd0", 32'(rd_dout), 32'd0);
        tick();
        check("rel_valid", 32'(out_valid), 32'd1);
        check("rel_data", 32'(out_data), 32'h5A);
        tick();
        check("rel_drain", 32'(out_valid), 32'd0);

        // single word
        load(8'hA5, 1);
        #1;
        check("sw_rd_n", 32'(rd_dout), 32'd1);
        tick();
        check("sw_rd_n1", 32'(rd_dout), 32'd0);
        check("sw_val_n1", 32'(out_valid), 32'd0);
        tick();
        check("sw_val_n2", 32'(out_valid), 32'd1);
        check("sw_dat_n2", 32'(out_data), 32'hA5);
        check("sw_rd_n2", 32'(rd_dout), 32'd0);
        tick();
        check("sw_val_n3", 32'(out_valid), 32'd0);

        // streaming 0x01..0x08
        load(8'h01, 8);
        #1;
        check("st_rd", 32'(rd_dout), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("st_valid", 32'(out_valid), 32'((i >= 2) && (i <= 9)));
            if (i >= 2 && i <= 9) begin
                check("st_data", 32'(out_data), 32'(i - 1));
                check("st_cnt", 32'(dut.buf_cnt), 32'd1);
            end
        end
        check("st_popped", 32'(frp), 32'(fwp));

        // backpressure
        start = fwp;
        load(8'h01, 8);
        #1;
        check("bp_rd", 32'(rd_dout), 32'd1);
        tick();
        tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data0", 32'(out_data), 32'h01);
        out_ready = 1'b0;
        #1;
        check("bp_rd_stall", 32'(rd_dout), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("bp_rd_hold", 32'(rd_dout), 32'd0);
            check("bp_cnt", 32'(dut.buf_cnt), 32'd2);
            check("bp_data", 32'(out_data), 32'h01);
        end
        check("bp_pops", 32'(frp - start), 32'd2);
        out_ready = 1'b1;
        #1;
        check("bp_release_rd", 32'(rd_dout), 32'd1);
        exp_w = 1;
        for (int c = 0; c < 30 && exp_w <= 8; c++) begin
            if (out_valid) begin
                check("bp_order", 32'(out_data), 32'(exp_w));
                exp_w++;
            end
            tick();
        end
        check("bp_count", 32'(exp_w), 32'd9);
        check("bp_idle", 32'(out_valid), 32'd0);
        check("bp_popped", 32'(frp), 32'(fwp));

        // flush with one buffered and one in flight
        load(8'h11, 4);
        #1;
        check("fl_rd", 32'(rd_dout), 32'd1);
        tick();
        tick();
        check("fl_cnt_pre", 32'(dut.buf_cnt), 32'd1);
        check("fl_infl_pre", 32'(dut.inflight), 32'd1);
        check("fl_data_pre", 32'(out_data), 32'h11);
        flush = 1'b1;
        #1;
        check("fl_rd_forced", 32'(rd_dout), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_cnt", 32'(dut.buf_cnt), 32'd0);
        check("fl_infl", 32'(dut.inflight), 32'd0);
        check("fl_data", 32'(out_data), 32'd0);
        check("fl_rd_resume", 32'(rd_dout), 32'd1);
        tick();
        check("fl_gap", 32'(out_valid), 32'd0);
        tick();
        check("fl_w3_v", 32'(out_valid), 32'd1);
        check("fl_w3_d", 32'(out_data), 32'h13);
        tick();
        check("fl_w4_v", 32'(out_valid), 32'd1);
        check("fl_w4_d", 32'(out_data), 32'h14);
        tick();
        check("fl_end", 32'(out_valid), 32'd0);

        // async reset mid-stream
        load(8'h21, 6);
        tick();
        tick();
        tick();
        check("ar_pre_v", 32'(out_valid), 32'd1);
        check("ar_pre_rd", 32'(rd_dout), 32'd1);
        #3;
        rst_n = 1'b0;
        fwp   = 6'd0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_rd", 32'(rd_dout), 32'd0);
        check("ar_cnt", 32'(dut.buf_cnt), 32'd0);
        check("ar_infl", 32'(dut.inflight), 32'd0);
        check("ar_head", 32'(dut.head), 32'd0);
        check("ar_tail", 32'(dut.tail), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_post", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
